// File: rtl/orbit_serializer.sv
// orbit_serializer: telemetry word serializer with phrase/group/frame markers.
// Ports: iClkOrb/reset clock and async active-low reset; iEn run request;
//   iMode rate select; iBufRdy next buffer half ready; iClrErr clear underrun;
//   iWord buffer data. oAddr/oRdEn buffer read; oSwitch active buffer half;
//   oOrbit serial line; oParallel/oVal word monitor; oGrpDone group pulse;
//   oUnderrun sticky error; oGrp/oFrm current group and frame.
module orbit_serializer #(
    parameter int              WORD_W   = 12,
    parameter int              ADDR_W   = 11,
    parameter int              BIT_CLKS = 4,
    parameter int              GRP_N    = 32,
    parameter int              FRM_N    = 128,
    parameter logic [31:0]     PHR_MASK = 32'h4504_0154,
    parameter logic [4*ADDR_W-1:0] GMARK_N =
        {11'd2000, 11'd1904, 11'd1872, 11'd1840},
    parameter logic [4*ADDR_W-1:0] GMARK_L =
        {11'd2032, 11'd1968, 11'd1936, 11'd1808},
    parameter int              FMARK    = 240
) (
    input  logic              iClkOrb,
    input  logic              reset,
    input  logic              iEn,
    input  logic [1:0]        iMode,
    input  logic              iBufRdy,
    input  logic              iClrErr,
    input  logic [WORD_W-1:0] iWord,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRdEn,
    output logic              oSwitch,
    output logic              oOrbit,
    output logic [WORD_W-1:0] oParallel,
    output logic              oVal,
    output logic              oGrpDone,
    output logic              oUnderrun,
    output logic [4:0]        oGrp,
    output logic [6:0]        oFrm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN
    } state_t;

    localparam int GRP_W = (GRP_N > 1) ? $clog2(GRP_N) : 1;
    localparam int FRM_W = (FRM_N > 1) ? $clog2(FRM_N) : 1;
    localparam int CNT_W = $clog2(4 * BIT_CLKS);
    localparam int BIT_W = $clog2(WORD_W);

    state_t            state_q;
    logic [1:0]        rate_q;
    logic [CNT_W-1:0]  clk_q;
    logic [BIT_W-1:0]  bit_q;
    logic [ADDR_W-1:0] idx_q;
    logic [GRP_W-1:0]  grp_q;
    logic [FRM_W-1:0]  frm_q;
    logic [WORD_W-1:0] sh_q;
    logic              pend_q;
    logic              stop_q;

    logic [CNT_W-1:0]  p_last;
    logic              bit_end;
    logic              pre_bit;
    logic              last_bit;
    logic              idx_last;
    logic              grp_last;
    logic              frm_last;
    logic [ADDR_W-1:0] idx_d;
    logic [GRP_W-1:0]  grp_d;
    logic [FRM_W-1:0]  frm_d;
    logic              mark_d;
    logic [WORD_W-1:0] word_d;

    // Mode 3 behaves like mode 1; value is the log2 bit-period multiplier.
    function automatic logic [1:0] rate_sel(input logic [1:0] m);
        return (m == 2'd2) ? 2'd2 : (m == 2'd0) ? 2'd0 : 2'd1;
    endfunction

    always_comb begin
        p_last   = CNT_W'((BIT_CLKS << rate_q) - 1);
        bit_end  = (clk_q == p_last);
        pre_bit  = (bit_q == BIT_W'(WORD_W - 2));
        last_bit = (bit_q == BIT_W'(WORD_W - 1));
        idx_last = &idx_q;
        grp_last = (grp_q == GRP_W'(GRP_N - 1));
        frm_last = (frm_q == FRM_W'(FRM_N - 1));

        // Position of the word about to be loaded: the current one when
        // starting from LOAD, the following one at a RUN word boundary.
        idx_d = idx_q;
        grp_d = grp_q;
        frm_d = frm_q;
        if (state_q == S_RUN) begin
            idx_d = idx_q + 1'b1;
            if (idx_last) begin
                grp_d = grp_last ? '0 : grp_q + 1'b1;
                if (grp_last) begin
                    frm_d = frm_last ? '0 : frm_q + 1'b1;
                end
            end
        end

        mark_d = PHR_MASK[5'(idx_d)];
        for (int k = 0; k < 4; k++) begin
            if (grp_d != GRP_W'(GRP_N - 1) &&
                GMARK_N[k*ADDR_W +: ADDR_W] == idx_d) begin
                mark_d = 1'b1;
            end
            if (grp_d == GRP_W'(GRP_N - 1) &&
                GMARK_L[k*ADDR_W +: ADDR_W] == idx_d) begin
                mark_d = 1'b1;
            end
        end
        if (grp_d == '0 && frm_d == '0 &&
            32'(idx_d) == 32'(FMARK)) begin
            mark_d = 1'b1;
        end

        word_d = iWord;
        word_d[WORD_W-1] = iWord[WORD_W-1] | mark_d;
    end

    assign oGrp = 5'(grp_q);
    assign oFrm = 7'(frm_q);

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rate_q    <= 2'd0;
            clk_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            grp_q     <= '0;
            frm_q     <= '0;
            sh_q      <= '0;
            pend_q    <= 1'b0;
            stop_q    <= 1'b0;
            oAddr     <= '0;
            oRdEn     <= 1'b0;
            oSwitch   <= 1'b0;
            oOrbit    <= 1'b0;
            oParallel <= '0;
            oVal      <= 1'b0;
            oGrpDone  <= 1'b0;
            oUnderrun <= 1'b0;
        end else begin
            oRdEn    <= 1'b0;
            oVal     <= 1'b0;
            oGrpDone <= 1'b0;
            // A later set in this block overrides the clear.
            if (iClrErr) begin
                oUnderrun <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    oOrbit <= 1'b0;
                    if (iEn) begin
                        rate_q  <= rate_sel(iMode);
                        state_q <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    oRdEn   <= 1'b1;
                    oAddr   <= '0;
                    pend_q  <= 1'b1;
                    state_q <= S_LOAD;
                end

                // First LOAD clock waits for the buffer's registered data.
                S_LOAD: begin
                    pend_q <= 1'b0;
                    if (!pend_q) begin
                        sh_q      <= word_d;
                        oOrbit    <= word_d[WORD_W-1];
                        oParallel <= word_d;
                        oVal      <= 1'b1;
                        clk_q     <= '0;
                        bit_q     <= '0;
                        state_q   <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!bit_end) begin
                        clk_q <= clk_q + 1'b1;
                    end else if (!last_bit) begin
                        clk_q  <= '0;
                        bit_q  <= bit_q + 1'b1;
                        sh_q   <= sh_q << 1;
                        oOrbit <= sh_q[WORD_W-2];
                        // Entering the last bit: prefetch the next word.
                        if (pre_bit) begin
                            if (idx_last && !iEn) begin
                                stop_q <= 1'b1;
                            end else begin
                                oRdEn <= 1'b1;
                                oAddr <= idx_q + 1'b1;
                                if (idx_last) begin
                                    if (iBufRdy) begin
                                        oSwitch <= ~oSwitch;
                                    end else begin
                                        oUnderrun <= 1'b1;
                                    end
                                end
                            end
                        end
                    end else if (stop_q) begin
                        stop_q  <= 1'b0;
                        oOrbit  <= 1'b0;
                        idx_q   <= '0;
                        grp_q   <= '0;
                        frm_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        sh_q      <= word_d;
                        oOrbit    <= word_d[WORD_W-1];
                        oParallel <= word_d;
                        oVal      <= 1'b1;
                        clk_q     <= '0;
                        bit_q     <= '0;
                        idx_q     <= idx_d;
                        grp_q     <= grp_d;
                        frm_q     <= frm_d;
                        if (idx_last) begin
                            oGrpDone <= 1'b1;
                            rate_q   <= rate_sel(iMode);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_orbit_serializer.sv
// tb_orbit_serializer: directed test of orbit_serializer with a small
// geometry (32-word groups, 4 groups/frame) and a registered buffer model.
module tb_orbit_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iEn = 1'b0;
    logic [1:0]  iMode = 2'd0;
    logic        iBufRdy = 1'b0;
    logic        iClrErr = 1'b0;
    logic [11:0] iWord = 12'h000;
    logic [4:0]  oAddr;
    logic        oRdEn;
    logic        oSwitch;
    logic        oOrbit;
    logic [11:0] oParallel;
    logic        oVal;
    logic        oGrpDone;
    logic        oUnderrun;
    logic [4:0]  oGrp;
    logic [6:0]  oFrm;

    int checks = 0;
    int errors = 0;
    int wn = 0;
    int gap = 0;

    orbit_serializer #(
        .WORD_W(12), .ADDR_W(5), .BIT_CLKS(4),
        .GRP_N(4), .FRM_N(4), .PHR_MASK(32'h4504_0154),
        .GMARK_N({5'd29, 5'd21, 5'd13, 5'd9}),
        .GMARK_L({5'd31, 5'd27, 5'd15, 5'd11}),
        .FMARK(16)
    ) dut (
        .iClkOrb(clk), .reset(rst_n), .iEn(iEn), .iMode(iMode),
        .iBufRdy(iBufRdy), .iClrErr(iClrErr), .iWord(iWord),
        .oAddr(oAddr), .oRdEn(oRdEn), .oSwitch(oSwitch),
        .oOrbit(oOrbit), .oParallel(oParallel), .oVal(oVal),
        .oGrpDone(oGrpDone), .oUnderrun(oUnderrun),
        .oGrp(oGrp), .oFrm(oFrm)
    );

    always #5 clk = ~clk;

    // Buffer: word = {half in bit 8, address}, one clock read latency.
    always @(posedge clk) begin
        if (oRdEn) iWord <= {3'b000, oSwitch, 3'b000, oAddr};
    end

    task automatic next_word();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!oVal && n < 400);
        gap = n;
        wn++;
        checks++;
        if (!oVal) begin
            errors++;
            $display("FAIL word_timeout wn=%0d no oVal after %0d clocks", wn, n);
        end
    endtask

    task automatic goto(input int target);
        while (wn < target) next_word();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({oAddr, oRdEn, oSwitch, oOrbit, oParallel, oVal, oGrpDone,
             oUnderrun, oGrp, oFrm} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got par=%h orb=%b grp=%0d", oParallel, oOrbit, oGrp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        logic [11:0] ex;
        ex = 12'h802;
        iMode = 2'd0;
        iBufRdy = 1'b1;
        @(negedge clk);
        iEn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (oRdEn !== 1'b0) begin errors++; $display("FAIL start_t rdEn got %b exp 0", oRdEn); end
        @(posedge clk); #1;
        checks++;
        if (oRdEn !== 1'b1 || oAddr !== 5'd0) begin
            errors++; $display("FAIL start_t1 rdEn=%b addr=%0d exp 1/0", oRdEn, oAddr);
        end
        @(posedge clk); #1;
        checks++;
        if (oVal !== 1'b0 || oRdEn !== 1'b0) begin
            errors++; $display("FAIL start_t2 val=%b rdEn=%b exp 0/0", oVal, oRdEn);
        end
        @(posedge clk); #1;
        checks++;
        if (oVal !== 1'b1 || oParallel !== 12'h000 || oOrbit !== 1'b0) begin
            errors++; $display("FAIL start_t3 val=%b par=%h orb=%b exp 1/000/0", oVal, oParallel, oOrbit);
        end
        for (int c = 1; c <= 144; c++) begin
            @(posedge clk); #1;
            if (c == 43 || c == 44) begin
                checks++;
                if (oRdEn !== (c == 44) || (c == 44 && oAddr !== 5'd1)) begin
                    errors++; $display("FAIL prefetch c=%0d rdEn=%b addr=%0d", c, oRdEn, oAddr);
                end
            end
            if (c == 47) begin
                checks++;
                if (oVal !== 1'b0) begin errors++; $display("FAIL word_gap47 val=%b exp 0", oVal); end
            end
            if (c == 48) begin
                checks++;
                if (oVal !== 1'b1 || oParallel !== 12'h001) begin
                    errors++; $display("FAIL word1 val=%b par=%h exp 1/001", oVal, oParallel);
                end
            end
            if (c == 96) begin
                checks++;
                if (oVal !== 1'b1 || oParallel !== 12'h802) begin
                    errors++; $display("FAIL word2_phrase val=%b par=%h exp 1/802", oVal, oParallel);
                end
            end
            if (c >= 96 && c < 144 && (c - 96) % 4 == 0) begin
                checks++;
                if (oOrbit !== ex[11 - (c - 96) / 4]) begin
                    errors++; $display("FAIL orbit_bit%0d got %b exp %b", (c - 96) / 4, oOrbit, ex[11 - (c - 96) / 4]);
                end
            end
            if (c == 144) begin
                checks++;
                if (oVal !== 1'b1 || oParallel !== 12'h003) begin
                    errors++; $display("FAIL word3 val=%b par=%h exp 1/003", oVal, oParallel);
                end
            end
        end
        wn = 3;
    endtask

    task automatic test_markers();
        goto(16);
        checks++;
        if (oParallel !== 12'h810) begin errors++; $display("FAIL frame_mark got %h exp 810", oParallel); end
        goto(29);
        checks++;
        if (oParallel !== 12'h81D) begin errors++; $display("FAIL gmark_n29 got %h exp 81D", oParallel); end
        goto(32);
        checks++;
        if (oParallel !== 12'h100 || oSwitch !== 1'b1 || oGrp !== 5'd1 ||
            oGrpDone !== 1'b1 || oFrm !== 7'd0) begin
            errors++;
            $display("FAIL grp1_start par=%h sw=%b grp=%0d gd=%b frm=%0d exp 100/1/1/1/0",
                     oParallel, oSwitch, oGrp, oGrpDone, oFrm);
        end
        goto(41);
        checks++;
        if (oParallel !== 12'h909) begin errors++; $display("FAIL gmark_n9 got %h exp 909", oParallel); end
        goto(48);
        checks++;
        if (oParallel !== 12'h110) begin errors++; $display("FAIL fmark_grp1 got %h exp 110", oParallel); end
    endtask

    task automatic test_underrun();
        goto(52);
        iBufRdy = 1'b0;
        goto(64);
        checks++;
        if (oParallel !== 12'h100 || oSwitch !== 1'b1 || oUnderrun !== 1'b1 ||
            oGrp !== 5'd2 || oGrpDone !== 1'b1) begin
            errors++;
            $display("FAIL underrun par=%h sw=%b err=%b grp=%0d gd=%b exp 100/1/1/2/1",
                     oParallel, oSwitch, oUnderrun, oGrp, oGrpDone);
        end
        iClrErr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (oUnderrun !== 1'b0) begin errors++; $display("FAIL clr_err got %b exp 0", oUnderrun); end
        goto(66);
        checks++;
        if (oParallel !== 12'h902) begin errors++; $display("FAIL grp2_word2 got %h exp 902", oParallel); end
    endtask

    task automatic test_set_wins();
        int k = 0;
        bit found = 1'b0;
        checks++;
        if (oUnderrun !== 1'b0) begin errors++; $display("FAIL pre_setwins err got %b exp 0", oUnderrun); end
        while (!found && k < 3000) begin
            @(posedge clk); #1; k++;
            if (oRdEn && oAddr == 5'd0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL boundary_timeout no addr0 read in %0d clocks", k);
        end
        checks++;
        if (oUnderrun !== 1'b1 || oSwitch !== 1'b1) begin
            errors++; $display("FAIL set_wins err=%b sw=%b exp 1/1", oUnderrun, oSwitch);
        end
        iClrErr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (oUnderrun !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", oUnderrun); end
        iBufRdy = 1'b1;
        wn = 95;
    endtask

    task automatic test_last_group();
        goto(96);
        checks++;
        if (oParallel !== 12'h100 || oGrp !== 5'd3 || oSwitch !== 1'b1) begin
            errors++; $display("FAIL grp3_start par=%h grp=%0d sw=%b exp 100/3/1", oParallel, oGrp, oSwitch);
        end
        goto(105);
        checks++;
        if (oParallel !== 12'h109) begin errors++; $display("FAIL grp3_w9 got %h exp 109", oParallel); end
        goto(107);
        checks++;
        if (oParallel !== 12'h90B) begin errors++; $display("FAIL grp3_w11 got %h exp 90B", oParallel); end
        goto(125);
        checks++;
        if (oParallel !== 12'h11D) begin errors++; $display("FAIL grp3_w29 got %h exp 11D", oParallel); end
        goto(127);
        checks++;
        if (oParallel !== 12'h91F) begin errors++; $display("FAIL grp3_w31 got %h exp 91F", oParallel); end
        goto(128);
        checks++;
        if (oParallel !== 12'h000 || oGrp !== 5'd0 || oFrm !== 7'd1 || oSwitch !== 1'b0) begin
            errors++;
            $display("FAIL frame_wrap par=%h grp=%0d frm=%0d sw=%b exp 000/0/1/0",
                     oParallel, oGrp, oFrm, oSwitch);
        end
        goto(144);
        checks++;
        if (oParallel !== 12'h010) begin errors++; $display("FAIL frm1_w16 got %h exp 010", oParallel); end
    endtask

    task automatic test_stop();
        bit seen = 1'b0;
        iEn = 1'b0;
        goto(159);
        checks++;
        if (oParallel !== 12'h01F) begin errors++; $display("FAIL last_word got %h exp 01F", oParallel); end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (oVal) seen = 1'b1;
            if (c == 48) begin
                checks++;
                if (oOrbit !== 1'b0) begin errors++; $display("FAIL idle_orbit got %b exp 0", oOrbit); end
            end
        end
        checks++;
        if (seen) begin errors++; $display("FAIL stop_val got 1 exp 0"); end
        checks++;
        if (oGrp !== 5'd0 || oFrm !== 7'd0) begin
            errors++; $display("FAIL stop_cnt grp=%0d frm=%0d exp 0/0", oGrp, oFrm);
        end
    endtask

    task automatic test_mode();
        iMode = 2'd2;
        iEn = 1'b1;
        wn = -1;
        next_word();
        checks++;
        if (gap !== 4 || oParallel !== 12'h000) begin
            errors++; $display("FAIL mode_start gap=%0d par=%h exp 4/000", gap, oParallel);
        end
        next_word();
        checks++;
        if (gap !== 192) begin errors++; $display("FAIL mode2_gap1 got %0d exp 192", gap); end
        next_word();
        checks++;
        if (gap !== 192 || oParallel !== 12'h802) begin
            errors++; $display("FAIL mode2_w2 gap=%0d par=%h exp 192/802", gap, oParallel);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (oOrbit !== 1'b1) begin errors++; $display("FAIL mode2_bit0 got %b exp 1", oOrbit); end
        @(posedge clk); #1;
        checks++;
        if (oOrbit !== 1'b0) begin errors++; $display("FAIL mode2_bit1 got %b exp 0", oOrbit); end
        iMode = 2'd0;
        goto(4);
        checks++;
        if (gap !== 192) begin errors++; $display("FAIL mode_hold got %0d exp 192", gap); end
        goto(32);
        checks++;
        if (gap !== 192 || oGrp !== 5'd1 || oGrpDone !== 1'b1) begin
            errors++; $display("FAIL mode_bnd gap=%0d grp=%0d gd=%b exp 192/1/1", gap, oGrp, oGrpDone);
        end
        goto(33);
        checks++;
        if (gap !== 48) begin errors++; $display("FAIL mode0_gap got %0d exp 48", gap); end
    endtask

    task automatic test_reset_mid();
        goto(34);
        checks++;
        if (oParallel !== 12'h902 || oOrbit !== 1'b1) begin
            errors++; $display("FAIL pre_reset par=%h orb=%b exp 902/1", oParallel, oOrbit);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({oAddr, oRdEn, oSwitch, oOrbit, oParallel, oVal, oGrpDone,
             oUnderrun, oGrp, oFrm} !== 35'd0) begin
            errors++; $display("FAIL async_reset par=%h orb=%b sw=%b grp=%0d", oParallel, oOrbit, oSwitch, oGrp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wn = -1;
        next_word();
        checks++;
        if (gap !== 4 || oParallel !== 12'h000 || oGrp !== 5'd0 || oSwitch !== 1'b0) begin
            errors++;
            $display("FAIL restart gap=%0d par=%h grp=%0d sw=%b exp 4/000/0/0", gap, oParallel, oGrp, oSwitch);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_markers();
        test_underrun();
        test_set_wins();
        test_last_group();
        test_stop();
        test_mode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
